uart_core: RTL and testbench

Parametrised full-duplex UART core: an 8N1/8E1-class serial transmitter and receiver with configurable data width, parity mode, stop bits and bit period, driven from one system clock. The bit period is generated internally. TX uses a valid/ready handshake. RX samples at mid-bit, reports per-frame errors, and buffers received frames in a small FIFO. It replaces fixed-format UART blocks and connects SoC-side logic to an external serial line or to a peer UART.

---
 rtl/uart_pkg.sv | 40 ++++
 rtl/uart_fifo.sv | 76 +++++++
 rtl/uart_core.sv | 284 ++++++++++++++++++++++++++++
 tb/tb_uart_core.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// =============================================================================
// uart_pkg : parity modes, TX/RX state encodings and frame helpers for uart_core
// Revision : 1.0
// =============================================================================
package uart_pkg;

   localparam int PAR_NONE = 0;
   localparam int PAR_EVEN = 1;
   localparam int PAR_ODD  = 2;

   typedef enum logic [2:0] {
      TX_IDLE   = 3'd0,
      TX_START  = 3'd1,
      TX_DATA   = 3'd2,
      TX_PARITY = 3'd3,
      TX_STOP   = 3'd4
   } tx_state_e;

   typedef enum logic [2:0] {
      RX_IDLE      = 3'd0,
      RX_START     = 3'd1,
      RX_DATA      = 3'd2,
      RX_PARITY    = 3'd3,
      RX_STOP      = 3'd4,
      RX_WAIT_HIGH = 3'd5
   } rx_state_e;

   function automatic int frame_cycles(input int data_bits, input int parity,
                                       input int stop_bits, input int clks_per_bit);
      return (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits) * clks_per_bit;
   endfunction

   // Data is zero-extended to 9 bits; the extra zeros do not change the XOR.
   function automatic logic parity_bit(input logic [8:0] data, input int mode);
      return (mode == PAR_ODD) ? ~(^data) : ^data;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// =============================================================================
// uart_fifo : synchronous show-ahead FIFO holding received UART frames
// Revision  : 1.0
// =============================================================================
module uart_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic             empty,
   output logic             full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0]   DEPTH_C = (PTR_W+1)'(DEPTH);
   localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
   localparam logic [PTR_W:0]   CNT_ONE = (PTR_W+1)'(1);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign empty     = (count_q == '0);
   assign full      = (count_q == DEPTH_C);
   assign do_pop    = pop && !empty;
   // A pop in the same cycle frees the slot, so a full FIFO still accepts.
   assign do_push   = push && (!full || do_pop);
   assign head_data = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_ONE;
         2'b01:   count_d = count_q - CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

endmodule
`default_nettype wire

// File: rtl/uart_core.sv
`default_nettype none
// =============================================================================
// uart_core : full-duplex UART with handshaked TX, mid-bit sampling RX and RX FIFO
// Revision  : 1.0
// =============================================================================
module uart_core
   import uart_pkg::*;
#(
   parameter int DATA_BITS     = 8,
   parameter int PARITY        = 1,
   parameter int STOP_BITS     = 1,
   parameter int CLKS_PER_BIT  = 16,
   parameter int RX_FIFO_DEPTH = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 tx,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_parity_err,
   output logic                 rx_frame_err,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 rx_overrun,
   output logic                 busy
);

   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam int BIT_W = 4;
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
   localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
   localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);
   localparam bit               HAS_PARITY = (PARITY != PAR_NONE);

   // ---------------------------------------------------------------- transmitter
   tx_state_e            tx_state_q, tx_state_d;
   logic [CNT_W-1:0]     tx_cnt_q, tx_cnt_d;
   logic [BIT_W-1:0]     tx_bit_q, tx_bit_d;
   logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
   logic                 tx_par_q, tx_par_d;
   logic                 tx_q, tx_d;
   logic                 tx_tick;
   logic                 tx_accept;

   assign tx_tick   = (tx_cnt_q == BIT_LAST);
   // Ready already in the last stop cycle so consecutive words leave no idle gap.
   assign tx_ready  = (tx_state_q == TX_IDLE) ||
                      ((tx_state_q == TX_STOP) && tx_tick && (tx_bit_q == STOP_LAST));
   assign busy      = ~tx_ready;
   assign tx_accept = tx_valid && tx_ready;
   assign tx        = tx_q;

   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_tick ? '0 : tx_cnt_q + CNT_ONE;
      tx_bit_d   = tx_bit_q;
      tx_shift_d = tx_shift_q;
      tx_par_d   = tx_par_q;
      tx_d       = tx_q;
      if (tx_accept) begin
         tx_state_d = TX_START;
         tx_cnt_d   = '0;
         tx_shift_d = tx_data;
         tx_par_d   = parity_bit(9'(tx_data), PARITY);
         tx_d       = 1'b0;
      end else begin
         case (tx_state_q)
            TX_IDLE: begin
               tx_cnt_d = '0;
               tx_d     = 1'b1;
            end
            TX_START: begin
               if (tx_tick) begin
                  tx_state_d = TX_DATA;
                  tx_bit_d   = '0;
                  tx_d       = tx_shift_q[0];
               end
            end
            TX_DATA: begin
               if (tx_tick) begin
                  if (tx_bit_q == DATA_LAST) begin
                     tx_bit_d = '0;
                     if (HAS_PARITY) begin
                        tx_state_d = TX_PARITY;
                        tx_d       = tx_par_q;
                     end else begin
                        tx_state_d = TX_STOP;
                        tx_d       = 1'b1;
                     end
                  end else begin
                     tx_shift_d = tx_shift_q >> 1;
                     tx_bit_d   = tx_bit_q + BIT_ONE;
                     tx_d       = tx_shift_q[1];
                  end
               end
            end
            TX_PARITY: begin
               if (tx_tick) begin
                  tx_state_d = TX_STOP;
                  tx_bit_d   = '0;
                  tx_d       = 1'b1;
               end
            end
            TX_STOP: begin
               if (tx_tick) begin
                  if (tx_bit_q == STOP_LAST) begin
                     tx_state_d = TX_IDLE;
                  end else begin
                     tx_bit_d = tx_bit_q + BIT_ONE;
                  end
               end
            end
            default: begin
               tx_state_d = TX_IDLE;
               tx_d       = 1'b1;
            end
         endcase
      end
   end

   // ------------------------------------------------------------------- receiver
   logic [1:0]           sync_q, sync_d;
   logic                 rx_s;
   rx_state_e            rx_state_q, rx_state_d;
   logic [CNT_W-1:0]     rx_cnt_q, rx_cnt_d;
   logic [BIT_W-1:0]     rx_bit_q, rx_bit_d;
   logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
   logic                 rx_perr_q, rx_perr_d;
   logic                 rx_ferr_q, rx_ferr_d;
   logic                 push_q, push_d;
   logic                 overrun_q, overrun_d;
   logic                 rx_tick;
   logic                 fifo_pop;
   logic                 fifo_empty;
   logic                 fifo_full;
   logic [DATA_BITS+1:0] fifo_head;

   assign sync_d  = {sync_q[0], rx};
   assign rx_s    = sync_q[1];
   assign rx_tick = (rx_cnt_q == BIT_LAST);

   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_tick ? '0 : rx_cnt_q + CNT_ONE;
      rx_bit_d   = rx_bit_q;
      rx_shift_d = rx_shift_q;
      rx_perr_d  = rx_perr_q;
      rx_ferr_d  = rx_ferr_q;
      push_d     = 1'b0;
      case (rx_state_q)
         RX_IDLE: begin
            rx_cnt_d = '0;
            if (!rx_s) begin
               rx_state_d = RX_START;
               rx_perr_d  = 1'b0;
               rx_ferr_d  = 1'b0;
            end
         end
         RX_START: begin
            // Half-bit re-check: a line back high by now was only a glitch.
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_bit_d   = '0;
               rx_state_d = rx_s ? RX_IDLE : RX_DATA;
            end
         end
         RX_DATA: begin
            if (rx_tick) begin
               rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
               if (rx_bit_q == DATA_LAST) begin
                  rx_bit_d   = '0;
                  rx_state_d = HAS_PARITY ? RX_PARITY : RX_STOP;
               end else begin
                  rx_bit_d = rx_bit_q + BIT_ONE;
               end
            end
         end
         RX_PARITY: begin
            if (rx_tick) begin
               rx_perr_d  = (rx_s != parity_bit(9'(rx_shift_q), PARITY));
               rx_bit_d   = '0;
               rx_state_d = RX_STOP;
            end
         end
         RX_STOP: begin
            if (rx_tick) begin
               if (!rx_s) begin
                  rx_ferr_d = 1'b1;
               end
               if (rx_bit_q == STOP_LAST) begin
                  push_d     = 1'b1;
                  rx_state_d = (rx_ferr_q || !rx_s) ? RX_WAIT_HIGH : RX_IDLE;
               end else begin
                  rx_bit_d = rx_bit_q + BIT_ONE;
               end
            end
         end
         RX_WAIT_HIGH: begin
            rx_cnt_d = '0;
            if (rx_s) begin
               rx_state_d = RX_IDLE;
            end
         end
         default: begin
            rx_state_d = RX_IDLE;
         end
      endcase
   end

   assign fifo_pop = rx_valid && rx_ready;

   always_comb begin
      overrun_d = overrun_q;
      if (fifo_pop) begin
         overrun_d = 1'b0;
      end else if (push_q && fifo_full) begin
         overrun_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         tx_state_q <= TX_IDLE;
         tx_cnt_q   <= '0;
         tx_bit_q   <= '0;
         tx_shift_q <= '0;
         tx_par_q   <= 1'b0;
         tx_q       <= 1'b1;
         sync_q     <= 2'b11;
         rx_state_q <= RX_IDLE;
         rx_cnt_q   <= '0;
         rx_bit_q   <= '0;
         rx_shift_q <= '0;
         rx_perr_q  <= 1'b0;
         rx_ferr_q  <= 1'b0;
         push_q     <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_bit_q   <= tx_bit_d;
         tx_shift_q <= tx_shift_d;
         tx_par_q   <= tx_par_d;
         tx_q       <= tx_d;
         sync_q     <= sync_d;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_bit_q   <= rx_bit_d;
         rx_shift_q <= rx_shift_d;
         rx_perr_q  <= rx_perr_d;
         rx_ferr_q  <= rx_ferr_d;
         push_q     <= push_d;
         overrun_q  <= overrun_d;
      end
   end

   uart_fifo #(
      .WIDTH (DATA_BITS + 2),
      .DEPTH (RX_FIFO_DEPTH)
   ) u_rx_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push_q),
      .push_data ({rx_perr_q, rx_ferr_q, rx_shift_q}),
      .pop       (fifo_pop),
      .head_data (fifo_head),
      .empty     (fifo_empty),
      .full      (fifo_full)
   );

   assign rx_valid      = ~fifo_empty;
   assign rx_data       = fifo_head[DATA_BITS-1:0];
   assign rx_frame_err  = fifo_head[DATA_BITS];
   assign rx_parity_err = fifo_head[DATA_BITS+1];
   assign rx_overrun    = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_core.sv
`default_nettype none
// =============================================================================
// tb_uart_core : directed + random frames checked against a bit-level frame model
// Revision     : 1.0
// =============================================================================
module tb_uart_core;

   localparam int DB    = 8;
   localparam int C     = 16;
   localparam int DEPTH = 4;

   logic clk   = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic [7:0] tx_data  = '0;
   logic       tx_valid = 1'b0;
   logic       rx_ready = 1'b0;
   logic       loop_en  = 1'b1;
   logic       rx_drv   = 1'b1;
   logic       tx_ready, tx, busy, rx_in;
   logic [7:0] rx_data;
   logic       rx_parity_err, rx_frame_err, rx_valid, rx_overrun;

   logic [7:0] odd_tx_data  = '0;
   logic       odd_tx_valid = 1'b0;
   logic       odd_rx_ready = 1'b0;
   logic       odd_loop_en  = 1'b1;
   logic       odd_rx_drv   = 1'b1;
   logic       odd_tx_ready, odd_tx, odd_busy, odd_rx_in;
   logic [7:0] odd_rx_data;
   logic       odd_rx_parity_err, odd_rx_frame_err, odd_rx_valid, odd_rx_overrun;

   assign rx_in     = loop_en ? tx : rx_drv;
   assign odd_rx_in = odd_loop_en ? odd_tx : odd_rx_drv;

   uart_core #(.DATA_BITS(DB), .PARITY(1), .STOP_BITS(1), .CLKS_PER_BIT(C),
               .RX_FIFO_DEPTH(DEPTH)) u_dut (
      .clk(clk), .reset(reset), .tx_data(tx_data), .tx_valid(tx_valid),
      .tx_ready(tx_ready), .tx(tx), .rx(rx_in), .rx_data(rx_data),
      .rx_parity_err(rx_parity_err), .rx_frame_err(rx_frame_err),
      .rx_valid(rx_valid), .rx_ready(rx_ready), .rx_overrun(rx_overrun), .busy(busy));

   uart_core #(.DATA_BITS(DB), .PARITY(2), .STOP_BITS(1), .CLKS_PER_BIT(C),
               .RX_FIFO_DEPTH(DEPTH)) u_dut_odd (
      .clk(clk), .reset(reset), .tx_data(odd_tx_data), .tx_valid(odd_tx_valid),
      .tx_ready(odd_tx_ready), .tx(odd_tx), .rx(odd_rx_in), .rx_data(odd_rx_data),
      .rx_parity_err(odd_rx_parity_err), .rx_frame_err(odd_rx_frame_err),
      .rx_valid(odd_rx_valid), .rx_ready(odd_rx_ready), .rx_overrun(odd_rx_overrun),
      .busy(odd_busy));

   int         checks = 0;
   int         errors = 0;
   logic [9:0] exp_q[$];
   bit         model_ovr = 1'b0;

   task automatic check(input string tag, input bit pass, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      if (!pass) begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Parity bit chosen so the total count of ones (data + parity) is even/odd.
   function automatic logic model_parity(input logic [8:0] d, input int n, input int mode);
      int ones = 0;
      for (int i = 0; i < n; i++) ones += int'(d[i]);
      if (mode == 1) return logic'(ones % 2);
      return logic'(1 - (ones % 2));
   endfunction

   function automatic int model_nbits(input int n, input int mode, input int sb);
      return 1 + n + ((mode != 0) ? 1 : 0) + sb;
   endfunction

   function automatic logic [15:0] model_frame(input logic [8:0] d, input int n,
                                               input int mode, input int sb);
      logic [15:0] f = '0;
      int          k = 1;
      for (int i = 0; i < n; i++) begin f[k] = d[i]; k++; end
      if (mode != 0) begin f[k] = model_parity(d, n, mode); k++; end
      for (int i = 0; i < sb; i++) begin f[k] = 1'b1; k++; end
      return f;
   endfunction

   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic expect_frame(input logic [7:0] d, input logic perr, input logic ferr);
      if (exp_q.size() < DEPTH) exp_q.push_back({perr, ferr, d});
      else model_ovr = 1'b1;
   endtask

   task automatic send_tx(input logic [7:0] d, output int len, output logic [15:0] bits,
                          output logic start_ok);
      int nb = model_nbits(DB, 1, 1);
      tx_data  = d;
      tx_valid = 1'b1;
      cycles(1);
      tx_valid = 1'b0;
      start_ok = (tx === 1'b0) && (tx_ready === 1'b0);
      bits     = '0;
      len      = 0;
      for (int i = 0; i < 40 * C; i++) begin
         if ((i % C) == C / 2 && (i / C) < nb) bits[i / C] = tx;
         if (tx_ready === 1'b1) begin len = i + 1; break; end
         cycles(1);
      end
   endtask

   task automatic drive_frame(input int target, input logic [7:0] d, input int mode,
                              input bit flip_par, input bit stop_low);
      logic [15:0] f  = model_frame(9'(d), DB, mode, 1);
      int          nb = model_nbits(DB, mode, 1);
      if (flip_par && mode != 0) f[1 + DB] = ~f[1 + DB];
      if (stop_low) f[nb - 1] = 1'b0;
      for (int i = 0; i < nb; i++) begin
         if (target == 0) rx_drv = f[i];
         else odd_rx_drv = f[i];
         cycles(C);
      end
   endtask

   task automatic wait_valid(input int target, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40 * C; i++) begin
         if (((target == 0) ? rx_valid : odd_rx_valid) === 1'b1) begin ok = 1'b1; break; end
         cycles(1);
      end
   endtask

   task automatic pop_check(input string tag);
      logic [9:0] e;
      bit         ok;
      wait_valid(0, ok);
      check({tag, "_valid"}, ok === 1'b1, 32'(ok), 32'(1'b1));
      e = (exp_q.size() != 0) ? exp_q.pop_front() : 10'h0;
      check({tag, "_data"}, rx_data === e[7:0], 32'(rx_data), 32'(e[7:0]));
      check({tag, "_ferr"}, rx_frame_err === e[8], 32'(rx_frame_err), 32'(e[8]));
      check({tag, "_perr"}, rx_parity_err === e[9], 32'(rx_parity_err), 32'(e[9]));
      rx_ready = 1'b1;
      cycles(1);
      rx_ready  = 1'b0;
      model_ovr = 1'b0;
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          len;
      logic [15:0] bits;
      logic [15:0] mf;
      logic        sok;
      logic        pb;
      logic [7:0]  w0, w1;
      bit          ok;
      logic [14:0] odd_state;

      // Reset state
      #1;
      cycles(3);
      check("rst_tx", tx === 1'b1, 32'(tx), 32'(1'b1));
      check("rst_tx_ready", tx_ready === 1'b1, 32'(tx_ready), 32'(1'b1));
      check("rst_busy", busy === 1'b0, 32'(busy), 32'(1'b0));
      check("rst_rx_valid", rx_valid === 1'b0, 32'(rx_valid), 32'(1'b0));
      check("rst_overrun", rx_overrun === 1'b0, 32'(rx_overrun), 32'(1'b0));
      check("rst_rx_data", rx_data === 8'h00, 32'(rx_data), 32'(8'h00));
      check("rst_perr", rx_parity_err === 1'b0, 32'(rx_parity_err), 32'(1'b0));
      check("rst_ferr", rx_frame_err === 1'b0, 32'(rx_frame_err), 32'(1'b0));
      odd_state = {odd_tx, odd_tx_ready, odd_busy, odd_rx_valid, odd_rx_overrun,
                   odd_rx_parity_err, odd_rx_frame_err, odd_rx_data};
      check("rst_odd_state", odd_state === {7'b1100000, 8'h00}, 32'(odd_state),
            32'({7'b1100000, 8'h00}));
      reset = 1'b1;
      cycles(2);

      // Loopback 0xA5, even parity
      send_tx(8'hA5, len, bits, sok);
      check("a5_start", sok === 1'b1, 32'(sok), 32'(1'b1));
      mf = model_frame(9'h0A5, DB, 1, 1);
      check("a5_bits", bits === mf, 32'(bits), 32'(mf));
      check("a5_parity_bit", bits[9] === 1'b0, 32'(bits[9]), 32'(1'b0));
      check("a5_len", len === (1 + DB + 1 + 1) * C, 32'(len), 32'((1 + DB + 1 + 1) * C));
      expect_frame(8'hA5, 1'b0, 1'b0);
      pop_check("a5_rx");

      // Back-to-back random words: second start bit must follow the first stop bit directly
      w0 = 8'($urandom);
      w1 = 8'($urandom);
      send_tx(w0, len, bits, sok);
      mf = model_frame(9'(w0), DB, 1, 1);
      check("b2b0_bits", bits === mf, 32'(bits), 32'(mf));
      expect_frame(w0, 1'b0, 1'b0);
      send_tx(w1, len, bits, sok);
      check("b2b1_nogap", sok === 1'b1, 32'(sok), 32'(1'b1));
      mf = model_frame(9'(w1), DB, 1, 1);
      check("b2b1_bits", bits === mf, 32'(bits), 32'(mf));
      expect_frame(w1, 1'b0, 1'b0);
      pop_check("b2b0_rx");
      pop_check("b2b1_rx");

      // Odd parity: TX parity bit for 0x01, then a corrupted parity bit on RX
      odd_tx_data  = 8'h01;
      odd_tx_valid = 1'b1;
      cycles(1);
      odd_tx_valid = 1'b0;
      cycles(9 * C + C / 2);
      pb = model_parity(9'h001, DB, 2);
      check("odd_tx_parity", odd_tx === pb, 32'(odd_tx), 32'(pb));
      wait_valid(1, ok);
      check("odd_loop_valid", ok === 1'b1, 32'(ok), 32'(1'b1));
      check("odd_loop_data", odd_rx_data === 8'h01, 32'(odd_rx_data), 32'(8'h01));
      check("odd_loop_perr", odd_rx_parity_err === 1'b0, 32'(odd_rx_parity_err), 32'(1'b0));
      odd_rx_ready = 1'b1;
      cycles(1);
      odd_rx_ready = 1'b0;
      cycles(2 * C);
      odd_loop_en = 1'b0;
      drive_frame(1, 8'h01, 2, 1'b1, 1'b0);
      wait_valid(1, ok);
      check("odd_bad_valid", ok === 1'b1, 32'(ok), 32'(1'b1));
      check("odd_bad_perr", odd_rx_parity_err === 1'b1, 32'(odd_rx_parity_err), 32'(1'b1));
      check("odd_bad_data", odd_rx_data === 8'h01, 32'(odd_rx_data), 32'(8'h01));
      check("odd_bad_ferr", odd_rx_frame_err === 1'b0, 32'(odd_rx_frame_err), 32'(1'b0));
      odd_rx_ready = 1'b1;
      cycles(1);
      odd_rx_ready = 1'b0;

      // Glitch rejection, then a normal frame to show RX is back in idle
      loop_en = 1'b0;
      rx_drv  = 1'b0;
      cycles(3);
      rx_drv = 1'b1;
      cycles(3 * C);
      check("glitch_no_push", rx_valid === 1'b0, 32'(rx_valid), 32'(1'b0));
      w0 = 8'($urandom);
      expect_frame(w0, 1'b0, 1'b0);
      drive_frame(0, w0, 1, 1'b0, 1'b0);
      pop_check("post_glitch");

      // Stop bit low (break): one frame only while the line stays low
      expect_frame(8'h3C, 1'b0, 1'b1);
      drive_frame(0, 8'h3C, 1, 1'b0, 1'b1);
      pop_check("break");
      cycles(2 * 11 * C);
      check("break_single", rx_valid === 1'b0, 32'(rx_valid), 32'(1'b0));
      rx_drv = 1'b1;
      cycles(C);
      w0 = 8'($urandom);
      expect_frame(w0, 1'b0, 1'b0);
      drive_frame(0, w0, 1, 1'b0, 1'b0);
      pop_check("post_break");

      // Overrun: five frames into a four-entry FIFO with no pops
      for (int i = 0; i < 5; i++) begin
         w0 = 8'($urandom);
         expect_frame(w0, 1'b0, 1'b0);
         drive_frame(0, w0, 1, 1'b0, 1'b0);
         cycles(2);
      end
      cycles(C);
      check("ovr_set", rx_overrun === model_ovr, 32'(rx_overrun), 32'(model_ovr));
      pop_check("ovr_pop0");
      check("ovr_clear", rx_overrun === model_ovr, 32'(rx_overrun), 32'(model_ovr));
      pop_check("ovr_pop1");
      pop_check("ovr_pop2");
      pop_check("ovr_pop3");
      check("ovr_drained", rx_valid === 1'b0, 32'(rx_valid), 32'(1'b0));

      // Reset in the middle of a loopback frame
      loop_en  = 1'b1;
      tx_data  = 8'($urandom);
      tx_valid = 1'b1;
      cycles(1);
      tx_valid = 1'b0;
      cycles(5 * C);
      reset = 1'b0;
      cycles(1);
      check("midrst_tx", tx === 1'b1, 32'(tx), 32'(1'b1));
      check("midrst_tx_ready", tx_ready === 1'b1, 32'(tx_ready), 32'(1'b1));
      check("midrst_rx_valid", rx_valid === 1'b0, 32'(rx_valid), 32'(1'b0));
      reset = 1'b1;
      cycles(12 * C);
      check("midrst_no_push", rx_valid === 1'b0, 32'(rx_valid), 32'(1'b0));
      w0 = 8'($urandom);
      send_tx(w0, len, bits, sok);
      mf = model_frame(9'(w0), DB, 1, 1);
      check("post_rst_bits", bits === mf, 32'(bits), 32'(mf));
      expect_frame(w0, 1'b0, 1'b0);
      pop_check("post_rst_rx");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
